// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the sequential LC-3 ALU (alu_seq) and its iterative
// multiplier (alu_mul_iter).
//   ALUK_W      : opcode width
//   aluk_e      : opcode encoding (0-3 match the legacy 2-bit ALU)
//   alu_flags_t : registered result flags {N, Z, P, C, V}
//   alu_state_e : sequencing FSM states
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int unsigned ALUK_W = 4;

   typedef enum logic [ALUK_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_AND  = 4'd1,
      ALU_NOT  = 4'd2,
      ALU_PASS = 4'd3,
      ALU_SUB  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_SHL  = 4'd7,
      ALU_SHR  = 4'd8,
      ALU_SRA  = 4'd9,
      ALU_MUL  = 4'd10
   } aluk_e;

   typedef struct packed {
      logic n;
      logic z;
      logic p;
      logic c;
      logic v;
   } alu_flags_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_e;

   // A zeroed Out reads as "zero", so Z is the only flag set out of reset.
   localparam alu_flags_t FLAGS_RST = '{n: 1'b0, z: 1'b1, p: 1'b0, c: 1'b0, v: 1'b0};

endpackage

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Shift-add multiplier producing the low WIDTH bits of unsigned a_i*b_i,
// one partial product per clock, WIDTH clocks per operation.
//   clk_i, rst_ni : clock, asynchronous active-low reset (aborts operation)
//   start_i       : load operands and begin (ignored while busy)
//   a_i, b_i      : multiplicand, multiplier
//   done_o        : high during the final iteration; result_o valid then
//   result_o      : final product, meaningful only while done_o=1
// -----------------------------------------------------------------------------
module alu_mul_iter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;

   // Accumulator value after this cycle's iteration; on the last iteration
   // it is the product, handed out combinationally so the caller can
   // register it on the same edge.
   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) begin
         acc_d = acc_q + mcand_q;
      end
   end

   assign done_o   = busy_q && (cnt_q == '0);
   assign result_o = acc_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (!busy_q) begin
         if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= CNT_W'(WIDTH - 1);
            busy_q   <= 1'b1;
         end
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - CNT_W'(1);
         if (cnt_q == '0) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Handshaked, registered LC-3 ALU with 4-bit opcodes and NZP/C/V flags.
//   Clk, Reset_n        : clock (rising edge), asynchronous active-low reset
//   In_valid/In_ready   : operation handshake for A, B, ALUK
//   A, B, ALUK          : operands (B doubles as shift amount) and opcode
//   Out_valid/Out_ready : result handshake
//   Out, N, Z, P, C, V  : registered result and flags
//   Illegal             : result came from a reserved opcode (passes A)
//   Busy                : iterative multiply in progress
// Single-cycle ops register their result on the accepting edge; MUL takes
// WIDTH further edges in the multiplier sub-block.
// -----------------------------------------------------------------------------
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              In_valid,
   output logic              In_ready,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   input  logic [ALUK_W-1:0] ALUK,
   output logic              Out_valid,
   input  logic              Out_ready,
   output logic [WIDTH-1:0]  Out,
   output logic              N,
   output logic              Z,
   output logic              P,
   output logic              C,
   output logic              V,
   output logic              Illegal,
   output logic              Busy
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned MSB = WIDTH - 1;
   localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

   alu_state_e       state_q;
   logic [WIDTH-1:0] out_q;
   alu_flags_t       flags_q;
   logic             illegal_q;
   logic             valid_q;

   aluk_e            op;
   logic             accept;
   logic             is_mul;
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   logic [WIDTH-1:0] res_d;
   logic             c_d;
   logic             v_d;
   logic             illegal_d;
   logic             mul_done;
   logic [WIDTH-1:0] mul_res;

   function automatic alu_flags_t mk_flags(input logic [WIDTH-1:0] r,
                                           input logic c, input logic v);
      alu_flags_t f;
      f.n = r[MSB];
      f.z = (r == '0);
      f.p = !f.n && !f.z;
      f.c = c;
      f.v = v;
      return f;
   endfunction

   assign op     = aluk_e'(ALUK);
   assign is_mul = MUL_EN && (op == ALU_MUL);
   assign shamt  = B[SHW-1:0];

   // The output slot must be empty or being drained this edge before a new
   // operation is taken; a MUL therefore always finds it free on completion.
   assign In_ready = (state_q == ST_IDLE) && (!valid_q || Out_ready);
   assign accept   = In_valid && In_ready;

   // SUB as A + ~B + 1 so the carry out reads as "no borrow".
   assign add_w = {1'b0, A} + {1'b0, B};
   assign sub_w = {1'b0, A} + {1'b0, ~B} + ONE_W;

   always_comb begin
      res_d     = A;
      c_d       = 1'b0;
      v_d       = 1'b0;
      illegal_d = 1'b0;
      case (op)
         ALU_ADD: begin
            res_d = add_w[WIDTH-1:0];
            c_d   = add_w[WIDTH];
            v_d   = (A[MSB] == B[MSB]) && (add_w[MSB] != A[MSB]);
         end
         ALU_AND:  res_d = A & B;
         ALU_NOT:  res_d = ~A;
         ALU_PASS: res_d = A;
         ALU_SUB: begin
            res_d = sub_w[WIDTH-1:0];
            c_d   = sub_w[WIDTH];
            v_d   = (A[MSB] != B[MSB]) && (sub_w[MSB] != A[MSB]);
         end
         ALU_OR:   res_d = A | B;
         ALU_XOR:  res_d = A ^ B;
         ALU_SHL:  res_d = A << shamt;
         ALU_SHR:  res_d = A >> shamt;
         ALU_SRA:  res_d = WIDTH'($signed(A) >>> shamt);
         // With the multiplier present the result comes from u_mul instead;
         // without it the opcode behaves as reserved.
         ALU_MUL:  illegal_d = !MUL_EN;
         default:  illegal_d = 1'b1;
      endcase
   end

   alu_mul_iter #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk_i    (Clk),
      .rst_ni   (Reset_n),
      .start_i  (accept && is_mul),
      .a_i      (A),
      .b_i      (B),
      .done_o   (mul_done),
      .result_o (mul_res)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= ST_IDLE;
         out_q     <= '0;
         flags_q   <= FLAGS_RST;
         illegal_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         // Consumption clears the slot; a result written this edge overrides.
         if (Out_ready) begin
            valid_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state_q <= ST_MUL;
                  end else begin
                     out_q     <= res_d;
                     flags_q   <= mk_flags(res_d, c_d, v_d);
                     illegal_q <= illegal_d;
                     valid_q   <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  out_q     <= mul_res;
                  flags_q   <= mk_flags(mul_res, 1'b0, 1'b0);
                  illegal_q <= 1'b0;
                  valid_q   <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign Out       = out_q;
   assign N         = flags_q.n;
   assign Z         = flags_q.z;
   assign P         = flags_q.p;
   assign C         = flags_q.c;
   assign V         = flags_q.v;
   assign Illegal   = illegal_q;
   assign Out_valid = valid_q;
   assign Busy      = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        In_valid;
   logic        In_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic [3:0]  ALUK;
   logic        Out_valid;
   logic        Out_ready;
   logic [15:0] Out;
   logic        N, Z, P, C, V, Illegal, Busy;

   typedef struct packed {
      logic [15:0] out;
      logic        n, z, p, c, v, ill;
   } exp_t;

   exp_t scb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 Clk = ~Clk;

   alu_seq #(
      .WIDTH (16),
      .MUL_EN(1'b1)
   ) dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .In_valid (In_valid),
      .In_ready (In_ready),
      .A        (A),
      .B        (B),
      .ALUK     (ALUK),
      .Out_valid(Out_valid),
      .Out_ready(Out_ready),
      .Out      (Out),
      .N        (N),
      .Z        (Z),
      .P        (P),
      .C        (C),
      .V        (V),
      .Illegal  (Illegal),
      .Busy     (Busy)
   );

   function automatic exp_t mk(input logic [15:0] r, input logic c, input logic v,
                               input logic ill);
      exp_t e;
      e.out = r;
      e.n   = r[15];
      e.z   = (r == 16'h0000);
      e.p   = (r != 16'h0000) && !r[15];
      e.c   = c;
      e.v   = v;
      e.ill = ill;
      return e;
   endfunction

   // Reference model built from integer arithmetic and bit loops.
   function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b);
      logic [15:0] r;
      logic [16:0] w;
      logic [31:0] prod;
      int          s;
      int          amt;
      amt = int'(b[3:0]);
      case (op)
         4'd0: begin
            w = {1'b0, a} + {1'b0, b};
            s = int'($signed(a)) + int'($signed(b));
            return mk(w[15:0], w[16], (s > 32767) || (s < -32768), 1'b0);
         end
         4'd1: return mk(a & b, 1'b0, 1'b0, 1'b0);
         4'd2: return mk(~a, 1'b0, 1'b0, 1'b0);
         4'd3: return mk(a, 1'b0, 1'b0, 1'b0);
         4'd4: begin
            s = int'($signed(a)) - int'($signed(b));
            return mk(a - b, a >= b, (s > 32767) || (s < -32768), 1'b0);
         end
         4'd5: return mk(a | b, 1'b0, 1'b0, 1'b0);
         4'd6: return mk(a ^ b, 1'b0, 1'b0, 1'b0);
         4'd7: return mk(a << amt, 1'b0, 1'b0, 1'b0);
         4'd8: return mk(a >> amt, 1'b0, 1'b0, 1'b0);
         4'd9: begin
            r = a;
            for (int i = 0; i < amt; i++) r = {r[15], r[15:1]};
            return mk(r, 1'b0, 1'b0, 1'b0);
         end
         4'd10: begin
            prod = {16'h0000, a} * {16'h0000, b};
            return mk(prod[15:0], 1'b0, 1'b0, 1'b0);
         end
         default: return mk(a, 1'b0, 1'b0, 1'b1);
      endcase
   endfunction

   // Scoreboard: every consumed result must match the oldest expectation.
   always @(negedge Clk) begin : monitor
      exp_t got;
      exp_t e;
      if (Reset_n === 1'b1 && Out_valid === 1'b1 && Out_ready === 1'b1) begin
         got = {Out, N, Z, P, C, V, Illegal};
         vectors++;
         if (scb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_result: got Out=%h NZPCV=%b%b%b%b%b Ill=%b, required no result",
                     Out, N, Z, P, C, V, Illegal);
         end else begin
            e = scb.pop_front();
            if (got !== e) begin
               miscompares++;
               $display("FAIL result: got Out=%h NZPCV=%b%b%b%b%b Ill=%b, required Out=%h NZPCV=%b%b%b%b%b Ill=%b",
                        Out, N, Z, P, C, V, Illegal, e.out, e.n, e.z, e.p, e.c, e.v, e.ill);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   // Presents one operation from a negedge, waits (bounded) for In_ready and
   // returns #1 after the transferring edge.
   task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit push, input exp_t e, output int waited);
      @(negedge Clk);
      In_valid = 1'b1;
      ALUK     = op;
      A        = a;
      B        = b;
      waited   = 0;
      while (In_ready !== 1'b1 && waited < 100) begin
         @(negedge Clk);
         waited++;
      end
      vectors++;
      if (In_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL accept_timeout: In_ready=%b after %0d cycles, required 1", In_ready, waited);
         In_valid = 1'b0;
      end else begin
         if (push) scb.push_back(e);
         @(posedge Clk);
         #1;
         In_valid = 1'b0;
      end
   endtask

   // Waits (bounded) until every expectation has been consumed, then moves
   // to #1 after a posedge so Out_ready may be changed race-free.
   task automatic drain();
      int n;
      n = 0;
      while (scb.size() != 0 && n < 200) begin
         @(negedge Clk);
         n++;
      end
      vectors++;
      if (scb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d results outstanding, required 0", scb.size());
         scb.delete();
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset_n   = 1'b0;
      In_valid  = 1'b0;
      Out_ready = 1'b1;
      A         = '0;
      B         = '0;
      ALUK      = '0;
      #12;
      vectors++;
      if ({Out, N, Z, P, C, V, Illegal, Busy, Out_valid, In_ready} !==
          {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_state: got Out=%h NZPCV=%b%b%b%b%b Ill=%b Busy=%b Ov=%b Ir=%b, required 0000 01000 0 0 0 1",
                  Out, N, Z, P, C, V, Illegal, Busy, Out_valid, In_ready);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_add_sub();
      int w;
      send(4'd0, 16'h7FFF, 16'h0001, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b0), w);
      @(negedge Clk);
      vectors++;
      if (Out_valid !== 1'b1 || Out !== 16'h8000) begin
         miscompares++;
         $display("FAIL add_latency: got Ov=%b Out=%h, required Ov=1 Out=8000", Out_valid, Out);
      end
      send(4'd4, 16'h0003, 16'h0005, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0), w);
      send(4'd4, 16'h0005, 16'h0003, 1'b1, mk(16'h0002, 1'b1, 1'b0, 1'b0), w);
      send(4'd0, 16'hFFFF, 16'h0001, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b0), w);
      send(4'd4, 16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0), w);
      drain();
   endtask

   task automatic test_back_to_back();
      int w0, w1, w2;
      send(4'd1, 16'hF0F0, 16'hFF00, 1'b1, mk(16'hF000, 1'b0, 1'b0, 1'b0), w0);
      send(4'd2, 16'h00FF, 16'h1234, 1'b1, mk(16'hFF00, 1'b0, 1'b0, 1'b0), w1);
      send(4'd3, 16'h0000, 16'hFFFF, 1'b1, mk(16'h0000, 1'b0, 1'b0, 1'b0), w2);
      vectors++;
      if (w0 + w1 + w2 != 0) begin
         miscompares++;
         $display("FAIL back_to_back_stall: got %0d stall cycles, required 0", w0 + w1 + w2);
      end
      @(negedge Clk);
      vectors++;
      if (Out_valid !== 1'b1 || Out !== 16'h0000 || Z !== 1'b1) begin
         miscompares++;
         $display("FAIL pass_zero: got Ov=%b Out=%h Z=%b, required Ov=1 Out=0000 Z=1", Out_valid, Out, Z);
      end
      drain();
   endtask

   task automatic test_mul();
      int w;
      send(4'd10, 16'h0123, 16'h0010, 1'b1, mk(16'h1230, 1'b0, 1'b0, 1'b0), w);
      for (int k = 0; k < 16; k++) begin
         @(negedge Clk);
         vectors++;
         if (Busy !== 1'b1 || In_ready !== 1'b0 || Out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_busy[%0d]: got Busy=%b Ir=%b Ov=%b, required 1 0 0", k, Busy, In_ready, Out_valid);
         end
      end
      @(negedge Clk);
      vectors++;
      if (Out_valid !== 1'b1 || Busy !== 1'b0 || Out !== 16'h1230) begin
         miscompares++;
         $display("FAIL mul_done: got Ov=%b Busy=%b Out=%h, required 1 0 1230", Out_valid, Busy, Out);
      end
      send(4'd10, 16'hFFFF, 16'hFFFF, 1'b1, mk(16'h0001, 1'b0, 1'b0, 1'b0), w);
      send(4'd10, 16'h0000, 16'hBEEF, 1'b1, mk(16'h0000, 1'b0, 1'b0, 1'b0), w);
      drain();
   endtask

   task automatic test_shift();
      int w;
      send(4'd9, 16'h8000, 16'h0013, 1'b1, mk(16'hF000, 1'b0, 1'b0, 1'b0), w);
      send(4'd8, 16'h8000, 16'h0013, 1'b1, mk(16'h1000, 1'b0, 1'b0, 1'b0), w);
      send(4'd7, 16'h0001, 16'h000F, 1'b1, mk(16'h8000, 1'b0, 1'b0, 1'b0), w);
      send(4'd7, 16'h1234, 16'h0010, 1'b1, mk(16'h1234, 1'b0, 1'b0, 1'b0), w);
      send(4'd9, 16'h8421, 16'hFFF0, 1'b1, mk(16'h8421, 1'b0, 1'b0, 1'b0), w);
      drain();
   endtask

   task automatic test_backpressure();
      int w;
      Out_ready = 1'b0;
      send(4'd0, 16'h0100, 16'h0023, 1'b1, mk(16'h0123, 1'b0, 1'b0, 1'b0), w);
      for (int k = 0; k < 5; k++) begin
         @(negedge Clk);
         vectors++;
         if (Out_valid !== 1'b1 || Out !== 16'h0123 || {N, Z, P, C, V} !== 5'b00100 ||
             In_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure[%0d]: got Ov=%b Out=%h NZPCV=%b%b%b%b%b Ir=%b, required 1 0123 00100 0",
                     k, Out_valid, Out, N, Z, P, C, V, In_ready);
         end
      end
      @(posedge Clk);
      #1;
      Out_ready = 1'b1;
      In_valid  = 1'b1;
      ALUK      = 4'd6;
      A         = 16'h00FF;
      B         = 16'h0F0F;
      @(negedge Clk);
      vectors++;
      if (In_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL release_ready: got In_ready=%b, required 1", In_ready);
      end
      scb.push_back(mk(16'h0FF0, 1'b0, 1'b0, 1'b0));
      @(posedge Clk);
      #1;
      In_valid = 1'b0;
      @(negedge Clk);
      vectors++;
      if (Out_valid !== 1'b1 || Out !== 16'h0FF0) begin
         miscompares++;
         $display("FAIL release_result: got Ov=%b Out=%h, required 1 0FF0", Out_valid, Out);
      end
      drain();
   endtask

   task automatic test_reserved();
      int w;
      send(4'd15, 16'h0000, 16'h1111, 1'b1, mk(16'h0000, 1'b0, 1'b0, 1'b1), w);
      send(4'd12, 16'h1234, 16'h5555, 1'b1, mk(16'h1234, 1'b0, 1'b0, 1'b1), w);
      drain();
   endtask

   task automatic test_reset_mid_mul();
      int w;
      bit bad;
      exp_t none;
      none = '0;
      send(4'd10, 16'h0003, 16'h0005, 1'b0, none, w);
      repeat (5) @(negedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      vectors++;
      if ({Out, N, Z, P, C, V, Illegal, Busy, Out_valid} !==
          {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL mid_mul_reset: got Out=%h NZPCV=%b%b%b%b%b Ill=%b Busy=%b Ov=%b, required 0000 01000 0 0 0",
                  Out, N, Z, P, C, V, Illegal, Busy, Out_valid);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      bad = 1'b0;
      repeat (20) begin
         @(negedge Clk);
         if (Out_valid !== 1'b0 || Busy !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL stale_after_reset: got late Out_valid/Busy activity, required none");
      end
      send(4'd3, 16'h4321, 16'h0000, 1'b1, mk(16'h4321, 1'b0, 1'b0, 1'b0), w);
      drain();
   endtask

   task automatic test_random();
      int w;
      logic [3:0]  op;
      logic [15:0] a, b;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = 16'($urandom);
         b  = 16'($urandom);
         send(op, a, b, 1'b1, model(op, a, b), w);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_back_to_back();
      test_mul();
      test_shift();
      test_backpressure();
      test_reserved();
      test_reset_mid_mul();
      test_random();
      repeat (3) @(negedge Clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
